regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised integer register file with N read ports and two prioritised write ports. Reads forward same-cycle writes, qualified by write enable. A per-register busy scoreboard supports hazard detection in the decode stage. A handshaked debug port (req/ack FSM) yields to pipeline writes. Sits between ID (read/issue), EX/LSU (writeback) and the JTAG debug module.

Parameters:
DW, 32, register data width
AW, 5, register address width; NREG = 2**AW registers
NRP, 2, number of read ports
RST_CLEAR, 1, 1: reset zeroes every register; 0: reset leaves array contents untouched

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
w0_we  in  1  primary write enable (EX writeback)
w0_addr  in  AW  primary write address
w0_data  in  DW  primary write data
w1_we  in  1  secondary write enable (load return)
w1_addr  in  AW  secondary write address
w1_data  in  DW  secondary write data
raddr  in  NRP*AW  read addresses, port i at [i*AW +: AW]
rdata  out  NRP*DW  read data, port i at [i*DW +: DW]
rbusy  out  NRP  port i register has an outstanding producer
issue_we  in  1  mark a destination register busy
issue_addr  in  AW  destination being issued
dbg_req  in  1  debug request, level, held until dbg_ack
dbg_we  in  1  1 = write, 0 = read; sampled with dbg_req
dbg_addr  in  AW  debug register address
dbg_wdata  in  DW  debug write data
dbg_ack  out  1  one-cycle completion pulse
dbg_rdata  out  DW  debug read result, valid from dbg_ack onward

Behaviour:
- Register x0 reads as 0. Writes to x0 are ignored on every port. x0 is never busy.
- Write commit: at the clk edge, w0 and w1 both commit when their addresses differ. When they target the same address, w0 wins.
- Read (combinational), per port i, in priority order:
  - raddr==0 -> 0
  - w0_we && w0_addr==raddr -> w0_data
  - w1_we && w1_addr==raddr -> w1_data
  - otherwise array value
- Forwarding requires the matching we; address match alone never forwards.
- Scoreboard busy[NREG]:
  - issue_we sets busy[issue_addr] at the next edge (address 0 excluded).
  - Any w0/w1 write to r clears busy[r].
  - Issue and write to the same r in the same cycle: set wins, because a new producer is in flight.
- rbusy[i] = busy[raddr_i] && no forwarding hit on port i this cycle.
- Debug FSM: IDLE -> ACCESS -> DONE -> IDLE.
  - IDLE: dbg_req=1 latches dbg_we/addr/wdata and moves to ACCESS.
  - ACCESS: if w0_we|w1_we, stay (pipeline has priority, unbounded stall). Otherwise:
    - write: commit dbg_wdata (ignored for addr 0);
    - read: load dbg_rdata with the array value (0 for addr 0);
    - then go to DONE.
  - DONE: dbg_ack=1 for this cycle only, then IDLE.
  - The requester drops dbg_req in the cycle after it sees ack. A req still high in IDLE starts a new transaction.
  - Minimum latency: req asserted in cycle 0 gives ack in cycle 2.
- Debug writes do not alter busy. Debug read data is held until the next debug read completes.
- Reset (rst=1 at edge):
  - busy cleared; FSM to IDLE; dbg_ack=0; dbg_rdata=0.
  - Registers zeroed if RST_CLEAR=1.
  - Any in-flight debug access is abandoned; no write commits.
  - During reset, pipeline and issue inputs are ignored.
- Array write visibility: next cycle via the array, same cycle via forwarding.

Test Plan:
1. Reset with RST_CLEAR=1, then read x1..x31 on both ports -> all 0, rbusy=0, dbg_ack=0.
2. w0 writes x5=0xDEADBEEF and w1 writes x5=0x12345678 in the same cycle. Read x5 in that cycle -> 0xDEADBEEF (forwarded). Read next cycle -> 0xDEADBEEF. Write x0=0xFFFFFFFF -> x0 reads 0.
3. Drive w0_addr=7 with w0_we=0 and w0_data=0xAAAA while x7=0x55 -> read x7 returns 0x55, confirming no unqualified forwarding.
4. Issue x9 -> rbusy=1 next cycle. w1 writes x9 -> rbusy=0 (forward) that cycle and 0 after. Issue x9 and w0 write x9 in the same cycle -> busy stays 1.
5. Debug write x3=0xCAFE with no pipeline writes -> ack in cycle 2 and x3=0xCAFE. Repeat with w0_we held high for 4 cycles -> ack delayed 4 cycles, and the pipeline writes are intact.
6. Start a debug read of x3, then assert rst while in ACCESS -> no ack, FSM in IDLE, dbg_rdata=0. After reset, a debug read of x3 returns 0.

Source files
------------

// File: rtl/regfile_sb.sv
// Integer register file: N read ports with same-cycle write forwarding,
// two prioritised write ports, a busy scoreboard and a debug access port.
module regfile_sb #(
  parameter int DW        = 32,
  parameter int AW        = 5,
  parameter int NRP       = 2,
  parameter int RST_CLEAR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w0_we,
  input  logic [AW-1:0]     w0_addr,
  input  logic [DW-1:0]     w0_data,
  input  logic              w1_we,
  input  logic [AW-1:0]     w1_addr,
  input  logic [DW-1:0]     w1_data,
  input  logic [NRP*AW-1:0] raddr,
  output logic [NRP*DW-1:0] rdata,
  output logic [NRP-1:0]    rbusy,
  input  logic              issue_we,
  input  logic [AW-1:0]     issue_addr,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [AW-1:0]     dbg_addr,
  input  logic [DW-1:0]     dbg_wdata,
  output logic              dbg_ack,
  output logic [DW-1:0]     dbg_rdata
);

  localparam int NREG = 1 << AW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_e;

  logic [DW-1:0]   regs_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  state_e          state_q, state_d;
  logic            dbg_we_q;
  logic [AW-1:0]   dbg_addr_q;
  logic [DW-1:0]   dbg_wdata_q;
  logic [DW-1:0]   dbg_rdata_q, dbg_rdata_d;
  logic            pipe_wr;
  logic            dbg_commit;

  assign pipe_wr = w0_we | w1_we;

  // Debug access only proceeds in a cycle with no pipeline write.
  always_comb begin
    state_d    = state_q;
    dbg_commit = 1'b0;
    unique case (state_q)
      S_IDLE:   if (dbg_req) state_d = S_ACCESS;
      S_ACCESS: if (!pipe_wr) begin
        dbg_commit = 1'b1;
        state_d    = S_DONE;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dbg_rdata_d = dbg_rdata_q;
    if (dbg_commit && !dbg_we_q) begin
      dbg_rdata_d = (dbg_addr_q == '0) ? '0 : regs_q[dbg_addr_q];
    end
  end

  // Issue sets after a same-cycle writeback clears: new producer in flight.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREG; r++) begin
      if ((w0_we && w0_addr == AW'(r)) || (w1_we && w1_addr == AW'(r)))
        busy_d[r] = 1'b0;
      if (issue_we && issue_addr == AW'(r))
        busy_d[r] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= '0;
      dbg_rdata_q <= '0;
      dbg_we_q    <= 1'b0;
      dbg_addr_q  <= '0;
      dbg_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      dbg_rdata_q <= dbg_rdata_d;
      if (state_q == S_IDLE && dbg_req) begin
        dbg_we_q    <= dbg_we;
        dbg_addr_q  <= dbg_addr;
        dbg_wdata_q <= dbg_wdata;
      end
    end
  end

  // w0 assigned last so it wins an address collision with w1.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (RST_CLEAR != 0) begin
        for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
      end
    end else begin
      if (dbg_commit && dbg_we_q && dbg_addr_q != '0)
        regs_q[dbg_addr_q] <= dbg_wdata_q;
      if (w1_we && w1_addr != '0)
        regs_q[w1_addr] <= w1_data;
      if (w0_we && w0_addr != '0)
        regs_q[w0_addr] <= w0_data;
    end
  end

  for (genvar i = 0; i < NRP; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit0, hit1;
    assign ra   = raddr[i*AW +: AW];
    assign hit0 = w0_we && (w0_addr == ra);
    assign hit1 = w1_we && (w1_addr == ra);
    assign rdata[i*DW +: DW] = (ra == '0) ? '0 :
                               hit0       ? w0_data :
                               hit1       ? w1_data :
                                            regs_q[ra];
    assign rbusy[i] = busy_q[ra] && !(hit0 || hit1);
  end

  assign dbg_ack   = (state_q == S_DONE);
  assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: forwarding, write priority, scoreboard,
// debug handshake latency/stall and reset abandonment.
module tb_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          w0_we, w1_we, issue_we;
  logic [AW-1:0] w0_addr, w1_addr, issue_addr;
  logic [DW-1:0] w0_data, w1_data;
  logic [2*AW-1:0] raddr;
  logic [2*DW-1:0] rdata;
  logic [1:0]    rbusy;
  logic          dbg_req, dbg_we, dbg_ack;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;

  int errs   = 0;
  int checks = 0;
  int n;

  regfile_sb #(.DW(DW), .AW(AW), .NRP(2), .RST_CLEAR(1)) dut (
    .clk(clk), .rst(rst),
    .w0_we(w0_we), .w0_addr(w0_addr), .w0_data(w0_data),
    .w1_we(w1_we), .w1_addr(w1_addr), .w1_data(w1_data),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .issue_we(issue_we), .issue_addr(issue_addr),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [AW-1:0] a1, input logic [AW-1:0] a0);
    raddr = {a1, a0};
    #1;
  endtask

  task automatic wait_ack(output int cnt);
    cnt = 0;
    while (!dbg_ack && cnt < 20) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    rst = 1'b1;
    {w0_we, w1_we, issue_we, dbg_req, dbg_we} = '0;
    {w0_addr, w1_addr, issue_addr, dbg_addr} = '0;
    {w0_data, w1_data, dbg_wdata} = '0;
    raddr = '0;
    tick();
    tick();
    rst = 1'b0;

    // 1: reset state
    for (int a = 1; a < 32; a++) begin
      rd(AW'(a), AW'(a));
      chk("rst_rd0", rdata[31:0], 32'h0);
      chk("rst_rd1", rdata[63:32], 32'h0);
      chk("rst_busy", {30'b0, rbusy}, 32'h0);
    end
    chk("rst_ack", {31'b0, dbg_ack}, 32'h0);

    // 2: w0 beats w1, forwarding, x0 hardwired
    tick();
    w0_we = 1; w0_addr = 5; w0_data = 32'hDEADBEEF;
    w1_we = 1; w1_addr = 5; w1_data = 32'h12345678;
    rd(5, 5);
    chk("fwd_w0_p0", rdata[31:0], 32'hDEADBEEF);
    chk("fwd_w0_p1", rdata[63:32], 32'hDEADBEEF);
    tick();
    w0_we = 0; w1_we = 0;
    rd(5, 5);
    chk("arr_x5", rdata[31:0], 32'hDEADBEEF);
    w0_we = 1; w0_addr = 0; w0_data = 32'hFFFFFFFF;
    rd(0, 0);
    chk("x0_fwd", rdata[31:0], 32'h0);
    tick();
    w0_addr = 6; w0_data = 32'h66;
    w1_we = 1; w1_addr = 7; w1_data = 32'h55;
    tick();
    w0_we = 0; w1_we = 0;
    rd(0, 0);
    chk("x0_arr", rdata[63:32], 32'h0);
    rd(7, 6);
    chk("dual_x6", rdata[31:0], 32'h66);
    chk("dual_x7", rdata[63:32], 32'h55);

    // 3: no unqualified forwarding
    w0_addr = 7; w0_data = 32'hAAAA;
    w1_addr = 7; w1_data = 32'hBBBB;
    rd(7, 7);
    chk("nofwd_x7", rdata[31:0], 32'h55);

    // 4: scoreboard
    tick();
    issue_we = 1; issue_addr = 9;
    rd(9, 9);
    chk("busy_pre", {30'b0, rbusy}, 32'h0);
    tick();
    issue_we = 0;
    rd(9, 9);
    chk("busy_set", {30'b0, rbusy}, 32'h3);
    w1_we = 1; w1_addr = 9; w1_data = 32'h99;
    rd(9, 9);
    chk("busy_fwd", {30'b0, rbusy}, 32'h0);
    chk("w1_fwd", rdata[31:0], 32'h99);
    tick();
    w1_we = 0;
    rd(9, 9);
    chk("busy_clr", {30'b0, rbusy}, 32'h0);
    issue_we = 1; issue_addr = 9;
    w0_we = 1; w0_addr = 9; w0_data = 32'h77;
    rd(9, 9);
    chk("busy_both_fwd", {30'b0, rbusy}, 32'h0);
    tick();
    issue_we = 0; w0_we = 0;
    rd(9, 9);
    chk("busy_setwins", {30'b0, rbusy}, 32'h3);
    chk("x9_val", rdata[63:32], 32'h77);
    issue_we = 1; issue_addr = 0;
    tick();
    issue_we = 0;
    rd(0, 0);
    chk("busy_x0", {30'b0, rbusy}, 32'h0);

    // 5: debug write, minimum latency then stalled by w0
    dbg_req = 1; dbg_we = 1; dbg_addr = 3; dbg_wdata = 32'hCAFE;
    wait_ack(n);
    chk("dbgw_lat", n, 2);
    dbg_req = 0;
    tick();
    chk("dbgw_ackpulse", {31'b0, dbg_ack}, 32'h0);
    rd(3, 3);
    chk("dbgw_x3", rdata[31:0], 32'hCAFE);

    dbg_req = 1; dbg_we = 1; dbg_addr = 20; dbg_wdata = 32'hBEEF;
    for (int k = 0; k < 4; k++) begin
      tick();
      w0_we = 1; w0_addr = AW'(10 + k); w0_data = 32'h1000 + k;
      chk("stall_noack", {31'b0, dbg_ack}, 32'h0);
    end
    tick();
    w0_we = 0;
    chk("stall_noack5", {31'b0, dbg_ack}, 32'h0);
    tick();
    chk("stall_ack6", {31'b0, dbg_ack}, 32'h1);
    dbg_req = 0;
    tick();
    rd(20, 10);
    chk("stall_x10", rdata[31:0], 32'h1000);
    chk("stall_x20", rdata[63:32], 32'hBEEF);
    rd(13, 11);
    chk("stall_x11", rdata[31:0], 32'h1001);
    chk("stall_x13", rdata[63:32], 32'h1003);

    // debug read, held afterwards
    dbg_req = 1; dbg_we = 0; dbg_addr = 3;
    wait_ack(n);
    chk("dbgr_lat", n, 2);
    chk("dbgr_data", dbg_rdata, 32'hCAFE);
    dbg_req = 0;
    tick();
    tick();
    chk("dbgr_hold", dbg_rdata, 32'hCAFE);

    // 6: reset during ACCESS
    issue_we = 1; issue_addr = 15;
    tick();
    issue_we = 0;
    rd(15, 15);
    chk("busy_x15", {30'b0, rbusy}, 32'h3);
    dbg_req = 1; dbg_we = 0; dbg_addr = 20;
    tick();
    rst = 1; dbg_req = 0;
    w0_we = 1; w0_addr = 21; w0_data = 32'h21;
    issue_we = 1; issue_addr = 16;
    tick();
    rst = 0; w0_we = 0; issue_we = 0;
    chk("rst_noack", {31'b0, dbg_ack}, 32'h0);
    chk("rst_rdata", dbg_rdata, 32'h0);
    rd(16, 15);
    chk("rst_busy15", {30'b0, rbusy}, 32'h0);
    rd(21, 3);
    chk("rst_x3", rdata[31:0], 32'h0);
    chk("rst_x21", rdata[63:32], 32'h0);
    tick();
    chk("rst_noack2", {31'b0, dbg_ack}, 32'h0);
    dbg_req = 1; dbg_we = 0; dbg_addr = 3;
    wait_ack(n);
    chk("post_lat", n, 2);
    chk("post_x3", dbg_rdata, 32'h0);
    dbg_req = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
